// File: rtl/sar_stim_gen_if.sv
// Bus bundle between the SAR stimulus generator and its environment:
// sweep control, SAR-under-test handshake, and sweep status.
interface sar_stim_gen_if #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [N-1:0]     fixed_code;
    logic [CNT_W-1:0] num_conv;
    logic [N-1:0]     dac_code;
    logic             sar_done;
    logic [N-1:0]     sar_out;
    logic             sar_start;
    logic             comp;
    logic [N-1:0]     vin_code;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] conv_cnt;
    logic [CNT_W-1:0] err_cnt;

    // Environment side: issues sweeps and plays the SAR under test.
    modport master (
        output start, mode, fixed_code, num_conv, dac_code, sar_done, sar_out,
        input  sar_start, comp, vin_code, busy, done, conv_cnt, err_cnt
    );

    // Generator side.
    modport slave (
        input  start, mode, fixed_code, num_conv, dac_code, sar_done, sar_out,
        output sar_start, comp, vin_code, busy, done, conv_cnt, err_cnt
    );
endinterface

// File: rtl/sar_stim_gen.sv
// SAR stimulus generator: emulates an analog input code and comparator for
// a SAR under test, runs sweeps of conversions, and counts result
// mismatches and conversion timeouts.
module sar_stim_gen #(
    parameter int unsigned N       = 5,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 12
) (
    input  logic           clk,
    input  logic           reset,
    sar_stim_gen_if.slave  bus
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, START, CONV, CHECK, NEXT, DONE
    } state_t;

    typedef enum logic [1:0] {
        M_FIXED = 2'b00,
        M_UP    = 2'b01,
        M_DOWN  = 2'b10,
        M_ALT   = 2'b11
    } mode_t;

    state_t           state;
    mode_t            mode_q;
    logic [CNT_W-1:0] num_q;
    logic [N-1:0]     sar_q;
    logic [TW-1:0]    timer;

    logic             sar_start_r;
    logic             comp_r;
    logic [N-1:0]     vin_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] conv_r;
    logic [CNT_W-1:0] err_r;

    logic [CNT_W-1:0] conv_inc;
    logic [CNT_W-1:0] err_inc;
    logic [N-1:0]     vin_first;
    logic [N-1:0]     vin_step;

    // Next-value helpers: incremented counters (err saturating) and vin codes.
    always_comb begin
        conv_inc  = conv_r + 1'b1;
        err_inc   = (err_r == '1) ? err_r : err_r + 1'b1;
        vin_first = bus.fixed_code;
        unique case (mode_t'(bus.mode))
            M_UP:    vin_first = '0;
            M_DOWN:  vin_first = '1;
            default: vin_first = bus.fixed_code;
        endcase
        vin_step = vin_r;
        unique case (mode_q)
            M_UP:    vin_step = vin_r + 1'b1;
            M_DOWN:  vin_step = vin_r - 1'b1;
            M_ALT:   vin_step = ~vin_r;
            default: vin_step = vin_r;
        endcase
    end

    // Sweep FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= M_FIXED;
            num_q       <= '0;
            sar_q       <= '0;
            timer       <= '0;
            sar_start_r <= 1'b0;
            comp_r      <= 1'b0;
            vin_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            conv_r      <= '0;
            err_r       <= '0;
        end else begin
            sar_start_r <= 1'b0;
            comp_r      <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mode_q <= mode_t'(bus.mode);
                        num_q  <= bus.num_conv;
                        vin_r  <= vin_first;
                        conv_r <= '0;
                        err_r  <= '0;
                        if (bus.num_conv == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end else begin
                            state       <= START;
                            sar_start_r <= 1'b1;
                            done_r      <= 1'b0;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                START: begin
                    timer <= '0;
                    state <= CONV;
                end
                CONV: begin
                    comp_r <= (vin_r >= bus.dac_code);
                    if (bus.sar_done) begin
                        sar_q <= bus.sar_out;
                        state <= CHECK;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err_r <= err_inc;
                        state <= NEXT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    if (sar_q != vin_r)
                        err_r <= err_inc;
                    state <= NEXT;
                end
                NEXT: begin
                    conv_r <= conv_inc;
                    if (conv_inc == num_q) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        vin_r       <= vin_step;
                        state       <= START;
                        sar_start_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sar_start = sar_start_r;
    assign bus.comp      = comp_r;
    assign bus.vin_code  = vin_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.conv_cnt  = conv_r;
    assign bus.err_cnt   = err_r;
endmodule

// File: doc/sar_stim_gen.md
SAR_STIM_GEN -- requirements
Module: sar_stim_gen

Interface
REQ-001 Parameter N, default 5: SAR resolution in bits.
REQ-002 Parameter CNT_W, default 8: width of conversion and error counters.
REQ-003 Parameter TIMEOUT, default 12: maximum cycles allowed in CONV waiting for sar_done.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 mode  input  2  sweep mode: 00 fixed, 01 ramp up, 10 ramp down, 11 alternate.
REQ-008 fixed_code  input  N  seed/fixed emulated input code.
REQ-009 num_conv  input  CNT_W  number of conversions per sweep.
REQ-010 dac_code  input  N  trial code driven by the SAR under test.
REQ-011 sar_done  input  1  SAR conversion-complete strobe.
REQ-012 sar_out  input  N  SAR result, valid with sar_done.
REQ-013 sar_start  output  1  one-cycle pulse launching one conversion.
REQ-014 comp  output  1  emulated comparator decision.
REQ-015 vin_code  output  N  current emulated analog input code.
REQ-016 busy  output  1  high while a sweep is in progress.
REQ-017 done  output  1  high from sweep end until the next accepted start.
REQ-018 conv_cnt  output  CNT_W  conversions completed in current/last sweep.
REQ-019 err_cnt  output  CNT_W  mismatches plus timeouts in current/last sweep.

Function
REQ-020 FSM states SHALL be IDLE, START, CONV, CHECK, NEXT, DONE.
REQ-021 IDLE/DONE + start: latch mode, fixed_code, num_conv; clear conv_cnt, err_cnt, done; load vin_code (fixed/alternate: fixed_code; up: 0; down: all ones); go START, or DONE directly if num_conv==0.
REQ-022 start in any other state SHALL be ignored; mode, fixed_code, num_conv changes mid-sweep SHALL have no effect.
REQ-023 START: sar_start=1 for exactly that cycle, timeout timer cleared, next state CONV.
REQ-024 comp SHALL be registered: comp at edge k+1 = (vin_code >= dac_code sampled at edge k, unsigned) while in CONV, else 0.
REQ-025 CONV + sar_done: capture sar_out, go CHECK.
REQ-026 CONV without sar_done: timer increments; when timer reaches TIMEOUT-1, err_cnt increments and next state NEXT (no CHECK).
REQ-027 CHECK: captured sar_out != vin_code increments err_cnt; next state NEXT.
REQ-028 err_cnt SHALL saturate at all ones; conv_cnt SHALL not exceed num_conv.
REQ-029 NEXT: conv_cnt increments; if new conv_cnt == num_conv go DONE, else update vin_code and go START.
REQ-030 vin_code update: fixed unchanged; up +1 mod 2^N; down -1 mod 2^N; alternate bitwise invert.
REQ-031 busy=1 in START, CONV, CHECK, NEXT; done=1 only in DONE.
REQ-032 Per-conversion period with prompt SAR = 1 (START) + conversion cycles + 1 (CHECK) + 1 (NEXT).

Reset
REQ-033 reset SHALL, at the next rising edge, force state IDLE and all outputs to 0 (sar_start, comp, vin_code, busy, done, conv_cnt, err_cnt), including mid-sweep.
REQ-034 reset SHALL take priority over start and sar_done in the same cycle.

Verification
REQ-035 N=5, ideal SAR model, mode 00, fixed_code 5'h13, num_conv 4 -> four sar_start pulses, vin_code 5'h13 throughout, done=1, conv_cnt 4, err_cnt 0.
REQ-036 Ideal SAR, mode 01, num_conv 40 -> vin_code 0..31 then wraps 0..7, err_cnt 0, conv_cnt 40.
REQ-037 mode 11, fixed_code 5'h0A, num_conv 3 -> vin_code sequence 0A, 15, 0A; SAR with bit 0 stuck at 0 -> err_cnt 1 (for 15).
REQ-038 SAR never asserts sar_done, num_conv 2 -> each conversion ends after TIMEOUT CONV cycles, err_cnt 2, done=1.
REQ-039 reset asserted in CONV of conversion 2 -> next edge all outputs 0, IDLE; start during busy ignored; num_conv 0 -> DONE with no sar_start.
